sr_mul_pipe: RTL and testbench
==============================

SR_MUL_PIPE -- requirements
Module: sr_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand and result width in bits (>= 8).
REQ-002 SHALL have parameter STAGES, 3, issue-to-result latency in cycles (>= 1).
REQ-003 SHALL have parameter TAG_W, 5, width of the destination tag carried with each operation.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have in_valid  input  1  operation offered.
REQ-007 SHALL have in_ready  output  1  operation accepted this cycle when high together with in_valid.
REQ-008 SHALL have in_op  input  2  mode: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 SHALL have in_a, in_b  input  WIDTH each  operands (srcA, srcB).
REQ-010 SHALL have in_tag  input  TAG_W  destination register tag.
REQ-011 SHALL have out_valid  output  1  result available.
REQ-012 SHALL have out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have out_result  output  WIDTH  selected product half.
REQ-014 SHALL have out_tag  output  TAG_W  tag of the result.
REQ-015 SHALL have flush  input  1  discard all in-flight operations.
REQ-016 SHALL have query_tag  input  TAG_W  tag probed for hazard checks.
REQ-017 SHALL have query_hit  output  1  an in-flight or presented operation carries query_tag.
REQ-018 SHALL have busy  output  1  any valid operation in the pipeline.

Function
REQ-019 Accept = in_valid & in_ready; in_ready = !stall & !flush, where stall = out_valid & !out_ready.
REQ-020 Pipeline SHALL be STAGES slots, each holding valid, op, tag and partial/full product; slot STAGES-1 drives out_*.
REQ-021 Accepted op SHALL appear with out_valid=1 exactly STAGES cycles after acceptance when no stall occurs.
REQ-022 Throughput SHALL be one op per cycle; results SHALL leave in acceptance order with their own tag.
REQ-023 On stall the whole pipeline SHALL hold; out_result/out_tag stable until out_ready.
REQ-024 Product SHALL be 2*WIDTH bits: MUL/MULH signed x signed, MULHSU signed a x unsigned b, MULHU unsigned x unsigned.
REQ-025 out_result SHALL be product[WIDTH-1:0] for MUL, product[2*WIDTH-1:WIDTH] otherwise; MUL result independent of signedness.
REQ-026 Bubble slots (valid=0) SHALL not assert out_valid; out_result/out_tag SHALL hold their last values when out_valid=0.
REQ-027 flush SHALL clear every slot valid bit at the next edge, including the slot presented on out_*, regardless of stall; no input accepted that cycle.
REQ-028 flush and out_ready in the same cycle: the presented result counts as consumed; no further results from flushed ops.
REQ-029 query_hit SHALL be combinational: OR over valid slots of (slot tag == query_tag); tag 0 SHALL never hit.
REQ-030 busy SHALL be OR of all slot valid bits.
REQ-031 STAGES=1: result registered once, out_valid the cycle after accept; stall and flush rules unchanged.

Reset
REQ-032 With rst high at an edge all slot valid bits, out_valid, busy and query_hit SHALL be 0, out_result and out_tag 0.
REQ-033 rst SHALL dominate flush and in_valid; in_ready SHALL be 0 during reset and 1 the cycle after.
REQ-034 Reset mid-operation SHALL discard all in-flight ops; none SHALL emerge afterwards.

Verification (WIDTH=32, STAGES=3)
REQ-035 MUL a=7, b=0xFFFFFFFD, tag=3 -> out_valid 3 cycles later, result 0xFFFFFFEB, tag 3.
REQ-036 MULH 0x80000000x0x80000000 -> 0x40000000; MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFFx2 -> 0xFFFFFFFF.
REQ-037 Ten back-to-back ops, out_ready=1 -> ten consecutive out_valid cycles, tags in issue order, no bubbles.
REQ-038 Three ops issued, out_ready low 4 cycles at first result -> in_ready 0 while stalled, out_* stable, all three delivered in order after release.
REQ-039 Two ops in flight, flush pulsed -> no out_valid for either, busy 0 next cycle, query_hit 0 for their tags; op issued after flush returns correctly.
REQ-040 rst asserted 1 cycle after issuing tag 7 -> out_valid never asserts for tag 7, all outputs 0, in_ready 1 after reset release.

Source files
------------

// File: rtl/sr_mul_pipe.sv
// rtl/sr_mul_pipe.sv - pipelined 32x32 multiplier (MUL/MULH/MULHSU/MULHU) with tags, stall, flush and hazard query
module sr_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    input  logic [TAG_W-1:0] query_tag,
    output logic             query_hit,
    output logic             busy
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    logic [STAGES-1:0]  vld_q, vld_d;
    logic [1:0]         op_q   [STAGES];
    logic [1:0]         op_d   [STAGES];
    logic [TAG_W-1:0]   tag_q  [STAGES];
    logic [TAG_W-1:0]   tag_d  [STAGES];
    logic [2*WIDTH-1:0] prod_q [STAGES];
    logic [2*WIDTH-1:0] prod_d [STAGES];

    logic               stall;
    logic               accept;
    logic               a_sgn;
    logic               b_sgn;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_in;

    assign out_valid = vld_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall & ~flush & ~rst;
    assign accept    = in_valid & in_ready;
    assign busy      = |vld_q;
    assign out_tag   = tag_q[STAGES-1];

    // Low 2*WIDTH bits of a product of sign/zero-extended operands give the exact signed/unsigned product
    always_comb begin
        a_sgn   = (in_op != OP_MULHU) & in_a[WIDTH-1];
        b_sgn   = ~in_op[1] & in_b[WIDTH-1];
        a_ext   = {{WIDTH{a_sgn}}, in_a};
        b_ext   = {{WIDTH{b_sgn}}, in_b};
        prod_in = a_ext * b_ext;
    end

    // Payload only moves with a valid op, so outputs keep their last value across bubbles and flushes
    always_comb begin
        vld_d  = vld_q;
        op_d   = op_q;
        tag_d  = tag_q;
        prod_d = prod_q;
        if (flush) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d[0] = accept;
            if (accept) begin
                op_d[0]   = in_op;
                tag_d[0]  = in_tag;
                prod_d[0] = prod_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    op_d[i]   = op_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                    prod_d[i] = prod_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_q[i]   <= '0;
                tag_q[i]  <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            tag_q  <= tag_d;
            prod_q <= prod_d;
        end
    end

    always_comb begin
        if (op_q[STAGES-1] == OP_MUL) out_result = prod_q[STAGES-1][WIDTH-1:0];
        else                          out_result = prod_q[STAGES-1][2*WIDTH-1:WIDTH];
    end

    // Tag 0 is the no-destination register and never creates a hazard
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (vld_q[i] && (tag_q[i] == query_tag)) query_hit = 1'b1;
        end
        if (query_tag == '0) query_hit = 1'b0;
    end

endmodule

// File: tb/tb_sr_mul_pipe.sv
// tb/tb_sr_mul_pipe.sv - scoreboard bench for sr_mul_pipe
module tb_sr_mul_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             flush = 1'b0;
    logic [TAG_W-1:0] query_tag = '0;
    logic             query_hit;
    logic             busy;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] nxt_exp = '0;
    logic             rnd_rdy = 1'b0;
    exp_t             sb[$];
    exp_t             head;

    sr_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .flush(flush), .query_tag(query_tag), .query_hit(query_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mul(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH+1:0] ax, bx, p;
        ax = (op == 2'b11) ? {{(WIDTH+2){1'b0}}, a} : {{(WIDTH+2){a[WIDTH-1]}}, a};
        bx = op[1] ? {{(WIDTH+2){1'b0}}, b} : {{(WIDTH+2){b[WIDTH-1]}}, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {59'b0, out_tag}, 64'h0);
                end else begin
                    head = sb.pop_front();
                    check("result", {32'b0, out_result}, {32'b0, head.res});
                    check("tag", {59'b0, out_tag}, {59'b0, head.tag});
                end
            end
        end
        if (rst || flush) sb.delete();
        if (in_valid && in_ready) sb.push_back({in_tag, nxt_exp});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        nxt_exp  = exp;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            step();
            if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
        end
        if (!acc) check("issue_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        logic done;
        done      = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int               ov_cnt;
        int               run;
        int               max_run;
        logic [1:0]       r_op;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [TAG_W-1:0] r_tag;

        // reset state
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_result", {32'b0, out_result}, 64'd0);
        check("rst_tag", {59'b0, out_tag}, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
        step();

        // single MUL: latency and value
        issue(2'b00, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB);
        for (int i = 1; i < STAGES; i++) begin
            @(negedge clk);
            check("lat_early", {63'b0, out_valid}, 64'd0);
        end
        @(negedge clk);
        check("lat_valid", {63'b0, out_valid}, 64'd1);
        check("mul_result", {32'b0, out_result}, 64'hFFFFFFEB);
        check("mul_tag", {59'b0, out_tag}, 64'd3);
        drain();

        // high-half modes
        issue(2'b01, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        issue(2'b10, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF);
        drain();

        // ten back-to-back ops with no bubbles
        ov_cnt  = 0;
        run     = 0;
        max_run = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    r_op = 2'($urandom_range(0, 3));
                    r_a  = $urandom;
                    r_b  = $urandom;
                    issue(r_op, r_a, r_b, 5'(i + 1), ref_mul(r_op, r_a, r_b));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        ov_cnt++;
                        run++;
                        if (run > max_run) max_run = run;
                    end else begin
                        run = 0;
                    end
                end
            end
        join
        check("b2b_count", 64'(ov_cnt), 64'd10);
        check("b2b_run", 64'(max_run), 64'd10);
        drain();

        // stall at first result for four cycles
        out_ready = 1'b0;
        issue(2'b00, 32'd100, 32'd200, 5'd5, 32'd20000);
        issue(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd6, ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678));
        issue(2'b01, 32'hFFFFFFF0, 32'h00000010, 5'd8, ref_mul(2'b01, 32'hFFFFFFF0, 32'h00000010));
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            check("stall_tag", {59'b0, out_tag}, 64'd5);
            check("stall_result", {32'b0, out_result}, 64'd20000);
        end
        step();
        drain();

        // flush two in-flight ops; the op offered alongside flush is refused
        issue(2'b00, 32'd3, 32'd4, 5'd10, 32'd12);
        issue(2'b00, 32'd5, 32'd6, 5'd11, 32'd30);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd12;
        @(negedge clk);
        check("flush_in_ready", {63'b0, in_ready}, 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_out_valid", {63'b0, out_valid}, 64'd0);
        query_tag = 5'd10;
        #1 check("flush_qhit10", {63'b0, query_hit}, 64'd0);
        query_tag = 5'd11;
        #1 check("flush_qhit11", {63'b0, query_hit}, 64'd0);
        idle(5);
        issue(2'b00, 32'd9, 32'd9, 5'd13, 32'd81);
        drain();

        // flush while a result is consumed
        issue(2'b00, 32'd2, 32'd2, 5'd14, 32'd4);
        issue(2'b00, 32'd3, 32'd3, 5'd15, 32'd9);
        issue(2'b00, 32'd4, 32'd4, 5'd16, 32'd16);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_cons_busy", {63'b0, busy}, 64'd0);
        idle(5);

        // hazard query; tag 0 never hits
        issue(2'b00, 32'd1, 32'd1, 5'd0, 32'd1);
        issue(2'b00, 32'd2, 32'd1, 5'd9, 32'd2);
        query_tag = 5'd9;
        @(negedge clk);
        check("qhit9", {63'b0, query_hit}, 64'd1);
        check("q_busy", {63'b0, busy}, 64'd1);
        query_tag = 5'd0;
        #1 check("qhit0", {63'b0, query_hit}, 64'd0);
        query_tag = 5'd12;
        #1 check("qhit12", {63'b0, query_hit}, 64'd0);
        drain();

        // reset one cycle after issuing tag 7
        issue(2'b00, 32'd7, 32'd7, 5'd7, 32'd49);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
        step();
        @(negedge clk);
        check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_busy", {63'b0, busy}, 64'd0);
        check("mid_rst_result", {32'b0, out_result}, 64'd0);
        check("mid_rst_tag", {59'b0, out_tag}, 64'd0);
        query_tag = 5'd7;
        #1 check("mid_rst_qhit", {63'b0, query_hit}, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release", {63'b0, in_ready}, 64'd1);
        idle(6);

        // random traffic with random back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_a   = $urandom;
            r_b   = $urandom;
            r_tag = 5'($urandom_range(0, 31));
            issue(r_op, r_a, r_b, r_tag, ref_mul(r_op, r_a, r_b));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_rdy = 1'b0;
        drain();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
